// File: rtl/fsm_seq_pkg.sv
// Shared types and step tables for the step-FSM sequencer.
package fsm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRECHK = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

  typedef logic [2:0] step_t;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       c;
    logic [3:0] d;
  } stim_t;

  localparam step_t      LAST_STEP  = 3'd4;
  localparam logic [2:0] ERR_PRECHK = 3'd5;

  localparam stim_t STIM_NONE = '{a: 1'b0, b: 1'b0, c: 1'b0, d: 4'b0000};
  localparam stim_t STIM_K0   = '{a: 1'b1, b: 1'b0, c: 1'b0, d: 4'b0000};
  localparam stim_t STIM_K1   = '{a: 1'b0, b: 1'b0, c: 1'b0, d: 4'b0001};
  localparam stim_t STIM_K2   = '{a: 1'b1, b: 1'b1, c: 1'b1, d: 4'b0000};
  localparam stim_t STIM_K3   = '{a: 1'b0, b: 1'b0, c: 1'b0, d: 4'b1111};

  // Q code the FSM must show after step k has been driven
  localparam logic [2:0] EXP_Q [0:4] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

  function automatic stim_t step_stim(input step_t k);
    case (k)
      3'd0:    return STIM_K0;
      3'd1:    return STIM_K1;
      3'd2:    return STIM_K2;
      3'd3:    return STIM_K3;
      default: return STIM_NONE;
    endcase
  endfunction

  function automatic logic [2:0] exp_q(input step_t k);
    if (k <= LAST_STEP) begin
      return EXP_Q[k];
    end else begin
      return 3'd0;
    end
  endfunction

endpackage

// File: rtl/fsm_step_sequencer_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick at/after the pointer, pointer moves past the grantee on advance.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  input  logic [$clog2(NUM_REQ)-1:0] adv_idx,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = IW + 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] pick_sum_s;
  logic [IW-1:0] pick_idx_s;
  logic          found_s;
  logic [SW-1:0] adv_sum_s;

  // first requester at or after the pointer, wrapping
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    found_s    = 1'b0;
    pick_sum_s = '0;
    pick_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_sum_s = {1'b0, ptr_q} + SW'(i);
      if (pick_sum_s >= SW'(NUM_REQ)) begin
        pick_sum_s = pick_sum_s - SW'(NUM_REQ);
      end else begin
        pick_sum_s = pick_sum_s;
      end
      pick_idx_s = pick_sum_s[IW-1:0];
      if (!found_s && req[pick_idx_s]) begin
        found_s           = 1'b1;
        grant[pick_idx_s] = 1'b1;
        grant_idx         = pick_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    adv_sum_s = {1'b0, adv_idx} + SW'(1);
    if (adv_sum_s >= SW'(NUM_REQ)) begin
      adv_sum_s = adv_sum_s - SW'(NUM_REQ);
    end else begin
      adv_sum_s = adv_sum_s;
    end
    if (advance) begin
      ptr_d = adv_sum_s[IW-1:0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fsm_step_sequencer.sv
// Shares one step FSM among NUM_REQ requesters: grants round-robin, walks S0..S4, checks Q each step.
// Optional macro FSM_SEQ_RETRY_EN: re-drive a failed step up to RETRY_MAX times before reporting err.
module fsm_step_sequencer #(
  parameter int NUM_REQ   = 4,
  parameter int RETRY_MAX = 7
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         err_step,
  output logic               drv_A,
  output logic               drv_B,
  output logic               drv_C,
  output logic [3:0]         drv_D,
  input  logic [2:0]         fsm_Q
);

  import fsm_seq_pkg::*;

  localparam int IW = $clog2(NUM_REQ);

  seq_state_t         state_q, state_d;
  step_t              k_q, k_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [2:0]         err_step_q, err_step_d;
  stim_t              drv_q, drv_d;

  logic [NUM_REQ-1:0] arb_grant_s;
  logic [IW-1:0]      arb_idx_s;
  logic               advance_s;

`ifdef FSM_SEQ_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 1);
  logic [RW-1:0] retry_q, retry_d;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`else
  // RETRY_MAX only shapes behaviour when retries are compiled in
  if (RETRY_MAX < 1) begin : g_retry_max_unused
  end
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rstN      (rstN),
    .req       (req),
    .advance   (advance_s),
    .adv_idx   (gidx_q),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s)
  );

  // next state plus the registered-output values for the coming cycle
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    gnt_d      = gnt_q;
    gidx_d     = gidx_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_step_d = 3'd0;
    advance_s  = 1'b0;
`ifdef FSM_SEQ_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_PRECHK;
          gnt_d   = arb_grant_s;
          gidx_d  = arb_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRECHK: begin
        if (fsm_Q == 3'd0) begin
          state_d = ST_DRIVE;
          k_d     = 3'd0;
`ifdef FSM_SEQ_RETRY_EN
          retry_d = '0;
`endif
        end else begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          err_d      = 1'b1;
          err_step_d = ERR_PRECHK;
        end
      end
      ST_DRIVE: begin
        state_d = ST_VERIFY;
      end
      ST_VERIFY: begin
        if (fsm_Q == exp_q(k_q)) begin
          if (k_q == LAST_STEP) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            k_d     = k_q + 3'd1;
`ifdef FSM_SEQ_RETRY_EN
            retry_d = '0;
`endif
          end
        end else begin
`ifdef FSM_SEQ_RETRY_EN
          // S4 always falls back to S0, so a miss there cannot be cured by re-driving
          if ((k_q != LAST_STEP) && (retry_q != RW'(RETRY_MAX))) begin
            state_d = ST_DRIVE;
            retry_d = retry_q + RW'(1);
          end else begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            err_d      = 1'b1;
            err_step_d = k_q;
          end
`else
          state_d    = ST_DONE;
          done_d     = 1'b1;
          err_d      = 1'b1;
          err_step_d = k_q;
`endif
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        advance_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    if (state_d == ST_DRIVE) begin
      drv_d = step_stim(k_d);
    end else begin
      drv_d = STIM_NONE;
    end
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= ST_IDLE;
      k_q        <= 3'd0;
      gnt_q      <= '0;
      gidx_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_step_q <= 3'd0;
      drv_q      <= STIM_NONE;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      gnt_q      <= gnt_d;
      gidx_q     <= gidx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_step_q <= err_step_d;
      drv_q      <= drv_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_step = err_step_q;
  assign drv_A    = drv_q.a;
  assign drv_B    = drv_q.b;
  assign drv_C    = drv_q.c;
  assign drv_D    = drv_q.d;

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// Directed bench for fsm_step_sequencer with a behavioural step FSM whose Q can be overridden.
module tb_fsm_step_sequencer;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       busy, done, err;
  logic [2:0] err_step;
  logic       drv_A, drv_B, drv_C;
  logic [3:0] drv_D;
  logic [2:0] fsm_Q;

  logic [2:0] fsm_st;
  logic       force_en = 1'b0;
  logic [2:0] force_val = 3'd0;
  logic [16:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_step_sequencer #(.NUM_REQ(4), .RETRY_MAX(3)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .req      (req),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_step (err_step),
    .drv_A    (drv_A),
    .drv_B    (drv_B),
    .drv_C    (drv_C),
    .drv_D    (drv_D),
    .fsm_Q    (fsm_Q)
  );

  // target step FSM: S0-A->S1-D=1->S2-ABC->S3-D=F->S4->S0
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fsm_st <= 3'd0;
    end else begin
      case (fsm_st)
        3'd0:    fsm_st <= drv_A ? 3'd1 : 3'd0;
        3'd1:    fsm_st <= (drv_D == 4'b0001) ? 3'd2 : 3'd1;
        3'd2:    fsm_st <= (drv_A && drv_B && drv_C) ? 3'd3 : 3'd2;
        3'd3:    fsm_st <= (drv_D == 4'b1111) ? 3'd4 : 3'd3;
        default: fsm_st <= 3'd0;
      endcase
    end
  end

  assign fsm_Q = force_en ? force_val : fsm_st;
  assign obs   = {gnt, busy, done, err, err_step, drv_A, drv_B, drv_C, drv_D};

  function automatic logic [16:0] mk(input logic [3:0] g, input logic d, input logic e,
                                     input logic [2:0] es, input logic [6:0] drv);
    return {g, |g, d, e, es, drv};
  endfunction

  // {A,B,C,D} for transaction cycle c of a clean pass
  function automatic logic [6:0] drv_at(input int c);
    case (c)
      2:       return 7'b1000000;
      4:       return 7'b0000001;
      6:       return 7'b1110000;
      8:       return 7'b0001111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstN = 1'b0;
    req  = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL reset_hold got %b want %b", obs, 17'd0);
    end
    rstN = 1'b1;
    tick();
    checks++;
    if (obs !== 17'd0 || fsm_Q !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle got %b q=%0d want %b q=0", obs, fsm_Q, 17'd0);
    end
  endtask

  task automatic test_single();
    logic [16:0] exp;
    req = 4'b0001;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 2) req = 4'b0000;
      exp = (c == 13) ? 17'd0 : mk(4'b0001, c == 12, 1'b0, 3'd0, drv_at(c));
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single c%0d got %b want %b", c, obs, exp);
      end
      if (c == 12) begin
        checks++;
        if (fsm_Q !== 3'd0) begin
          errors++;
          $display("FAIL single_q_home got %0d want 0", fsm_Q);
        end
      end
    end
  endtask

  task automatic test_rr();
    logic [3:0]  order [0:4];
    logic [16:0] exp;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      for (int c = 1; c <= 13; c++) begin
        tick();
        exp = (c == 13) ? 17'd0 : mk(order[t], c == 12, 1'b0, 3'd0, drv_at(c));
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL rr t%0d c%0d got %b want %b", t, c, obs, exp);
        end
        if (t == 4 && c == 12) req = 4'b0000;
      end
    end
  endtask

  task automatic test_precheck();
    logic [16:0] exp;
    force_val = 3'd3;
    force_en  = 1'b1;
    req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      req = 4'b0000;
      case (c)
        1:       exp = mk(4'b0100, 1'b0, 1'b0, 3'd0, 7'd0);
        2:       exp = mk(4'b0100, 1'b1, 1'b1, 3'd5, 7'd0);
        default: exp = 17'd0;
      endcase
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL precheck c%0d got %b want %b", c, obs, exp);
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [16:0] exp;
    req = 4'b0010;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) req = 4'b0000;
      exp = mk(4'b0010, 1'b0, 1'b0, 3'd0, drv_at(c));
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rstmid_pre c%0d got %b want %b", c, obs, exp);
      end
    end
    rstN = 1'b0;
    #1;
    checks++;
    if (obs !== 17'd0 || fsm_Q !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_async got %b q=%0d want 0", obs, fsm_Q);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs !== 17'd0) begin
        errors++;
        $display("FAIL rstmid_nodone got %b want 0", obs);
      end
    end
    rstN = 1'b1;
    req  = 4'b1010;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 2) req = 4'b0000;
      exp = (c == 13) ? 17'd0 : mk(4'b0010, c == 12, 1'b0, 3'd0, drv_at(c));
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rstmid_post c%0d got %b want %b", c, obs, exp);
      end
    end
  endtask

`ifdef FSM_SEQ_RETRY_EN
  task automatic test_retry();
    logic [16:0] exp;
    logic [6:0]  drv;
    req = 4'b0001;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 2) req = 4'b0000;
      case (c)
        2:              drv = 7'b1000000;
        4:              drv = 7'b0000001;
        6, 8, 10, 12:   drv = 7'b1110000;
        default:        drv = 7'b0000000;
      endcase
      exp = (c == 15) ? 17'd0 : mk(4'b0001, c == 14, c == 14, (c == 14) ? 3'd2 : 3'd0, drv);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL retry_err c%0d got %b want %b", c, obs, exp);
      end
      if (c == 5) begin
        force_val = 3'd2;
        force_en  = 1'b1;
      end
    end
    force_en = 1'b0;
    apply_reset();
    req = 4'b0001;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 2) req = 4'b0000;
      case (c)
        2:          drv = 7'b1000000;
        4:          drv = 7'b0000001;
        6, 8, 10:   drv = 7'b1110000;
        12:         drv = 7'b0001111;
        default:    drv = 7'b0000000;
      endcase
      exp = (c == 17) ? 17'd0 : mk(4'b0001, c == 16, 1'b0, 3'd0, drv);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL retry_recover c%0d got %b want %b", c, obs, exp);
      end
      if (c == 5) begin
        force_val = 3'd2;
        force_en  = 1'b1;
      end
      if (c == 10) force_en = 1'b0;
    end
  endtask
`else
  task automatic test_stuck();
    logic [16:0] exp;
    req = 4'b0011;
    for (int c = 1; c <= 7; c++) begin
      tick();
      case (c)
        6:       exp = mk(4'b0001, 1'b1, 1'b1, 3'd1, 7'd0);
        7:       exp = 17'd0;
        default: exp = mk(4'b0001, 1'b0, 1'b0, 3'd0, drv_at(c));
      endcase
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stuck c%0d got %b want %b", c, obs, exp);
      end
      if (c == 3) begin
        force_val = 3'd1;
        force_en  = 1'b1;
      end
      if (c == 6) req = 4'b0000;
    end
    force_en = 1'b0;
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_precheck();
    test_reset_mid();
`ifdef FSM_SEQ_RETRY_EN
    test_retry();
`else
    test_stuck();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
